// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the four-digit multiplexed seven-segment scanner.
// Holds the hex-to-segment table, SEG bit positions, the active-low "all off"
// constants, the per-slot phase type and the display record layout.
package seg_scan_ctrl_pkg;

  // SEG bus bit positions: {dp,g,f,e,d,c,b,a}
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Both buses are active-low, so all-ones turns everything off.
  localparam logic [7:0] SEG_OFF   = 8'hFF;
  localparam logic [3:0] DIGIT_OFF = 4'hF;

  // Active-low gfedcba pattern per hex value; element 15 comes first.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic {
    PhBlank,
    PhDrive
  } phase_e;

  // One complete display value: four nibbles plus per-digit dp and blank.
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } disp_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load-side bus between a value producer and seg_scan_ctrl.
//   data/dp/blank : value to display (data[3:0] is digit 0)
//   load          : one-cycle strobe capturing data/dp/blank into the shadow
//   pending       : shadow holds a value not yet shown
//   load_ack      : one-cycle pulse when the shadow value is committed
// master = producer, slave = scan controller.
interface seg_scan_ctrl_if;

  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        load;
  logic        pending;
  logic        load_ack;

  modport master (
    output data, dp, blank, load,
    input  pending, load_ack
  );

  modport slave (
    input  data, dp, blank, load,
    output pending, load_ack
  );

endinterface

// File: rtl/seg_hex_lut.sv
// Combinational hex nibble to active-low seven-segment (gfedcba) decode.
//   nib_i : hex value 0..F
//   seg_o : segment pattern, 0 = lit
module seg_hex_lut
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = HEX_SEG_TABLE[nib_i];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit time-multiplexed seven-segment scan controller.
// Each digit gets a slot of SCAN_DIV cycles; the first BLANK_CYC cycles of a
// slot are dark to suppress ghosting. New values are captured into a shadow
// register and only committed to the display register at frame start.
//   clk_i     : clock, rising edge
//   rst_ni    : synchronous active-low reset
//   enable_i  : 1 = scan, 0 = dark and held at frame start
//   load_io   : load bus (data/dp/blank/load in, pending/load_ack out)
//   frame_o   : one-cycle pulse at the start of each frame
//   seg_o     : {dp,g,f,e,d,c,b,a}, active-low
//   digit_o   : digit enables, active-low, at most one low
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 12500,
  parameter int unsigned BLANK_CYC = 250
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  seg_scan_ctrl_if.slave        load_io,
  output logic                  frame_o,
  output logic [7:0]            seg_o,
  output logic [3:0]            digit_o
);

  localparam int unsigned    CntW    = $clog2(SCAN_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  disp_t           shadow_q, shadow_d;
  disp_t           disp_q, disp_d;
  logic            pending_q, pending_d;
  logic            ack_q, ack_d;
  logic            frame_q, frame_d;
  logic [7:0]      seg_q, seg_d;
  logic [3:0]      digit_q, digit_d;

  phase_e          phase;
  logic [3:0]      nib;
  logic [6:0]      nib_seg;

  // With no blanking interval the compare would be against zero, so skip it.
  if (BLANK_CYC == 0) begin : g_no_blank
    assign phase = PhDrive;
  end else begin : g_blank
    assign phase = (cnt_q < CntW'(BLANK_CYC)) ? PhBlank : PhDrive;
  end

  assign nib = disp_q.data[{idx_q, 2'b00} +: 4];

  seg_hex_lut u_hex_lut (
    .nib_i (nib),
    .seg_o (nib_seg)
  );

  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    ack_d     = 1'b0;
    frame_d   = 1'b0;
    seg_d     = SEG_OFF;
    digit_d   = DIGIT_OFF;

    if (enable_i) begin
      if (cnt_q == CntLast) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end

      // Outputs use the display value as it stood before any commit this cycle.
      if (phase == PhDrive && !disp_q.blank[idx_q]) begin
        digit_d[idx_q]      = 1'b0;
        seg_d[SEG_DP]       = ~disp_q.dp[idx_q];
        seg_d[SEG_G:SEG_A]  = nib_seg;
      end

      if (cnt_q == '0 && idx_q == 2'd0) begin
        frame_d = 1'b1;
        if (pending_q) begin
          disp_d    = shadow_q;
          pending_d = 1'b0;
          ack_d     = 1'b1;
        end
      end
    end else begin
      cnt_d = '0;
      idx_d = 2'd0;
    end

    // A load on the commit cycle lands in the shadow after the old value was
    // taken, so it stays pending for the next frame.
    if (load_io.load) begin
      shadow_d  = '{data: load_io.data, dp: load_io.dp, blank: load_io.blank};
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      frame_q   <= 1'b0;
      seg_q     <= SEG_OFF;
      digit_q   <= DIGIT_OFF;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      frame_q   <= frame_d;
      seg_q     <= seg_d;
      digit_q   <= digit_d;
    end
  end

  assign load_io.pending  = pending_q;
  assign load_io.load_ack = ack_q;
  assign frame_o          = frame_q;
  assign seg_o            = seg_q;
  assign digit_o          = digit_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with SCAN_DIV = 8, BLANK_CYC = 2.
// A frame-position reference model checks every output each cycle; directed
// sequences and a vector table add explicit expectations on top.
module tb_seg_scan_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       frame;
  logic [7:0] seg;
  logic [3:0] digit;

  seg_scan_ctrl_if lif ();

  seg_scan_ctrl #(
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .enable_i (en),
    .load_io  (lif),
    .frame_o  (frame),
    .seg_o    (seg),
    .digit_o  (digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          mvalid = 0;
  int          m_pos;
  logic [15:0] m_sh_data, m_d_data;
  logic [3:0]  m_sh_dp, m_d_dp, m_sh_blank, m_d_blank;
  bit          m_pend;
  logic [7:0]  e_seg;
  logic [3:0]  e_dig;
  logic        e_frame, e_ack, e_pend;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predicts what the pins show after the coming edge, given current inputs.
  task automatic model_step();
    int s, c;
    if (!rst_n) begin
      mvalid = 1;
      m_pos = 0;
      {m_sh_data, m_sh_dp, m_sh_blank} = '0;
      {m_d_data, m_d_dp, m_d_blank} = '0;
      m_pend = 0;
      e_seg = 8'hFF; e_dig = 4'hF; e_frame = 0; e_ack = 0;
    end else begin
      e_seg = 8'hFF; e_dig = 4'hF; e_frame = 0; e_ack = 0;
      if (en) begin
        s = m_pos / SD;
        c = m_pos % SD;
        if (c >= BC && !m_d_blank[s]) begin
          e_dig = 4'hF ^ (4'b0001 << s);
          e_seg = {~m_d_dp[s], hex7(m_d_data[4*s +: 4])};
        end
        if (m_pos == 0) begin
          e_frame = 1;
          if (m_pend) begin
            {m_d_data, m_d_dp, m_d_blank} = {m_sh_data, m_sh_dp, m_sh_blank};
            m_pend = 0;
            e_ack = 1;
          end
        end
        m_pos = (m_pos + 1) % (4 * SD);
      end else begin
        m_pos = 0;
      end
      if (lif.load) begin
        {m_sh_data, m_sh_dp, m_sh_blank} = {lif.data, lif.dp, lif.blank};
        m_pend = 1;
      end
    end
    e_pend = m_pend;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (mvalid) begin
      check("model_seg", 32'(seg), 32'(e_seg));
      check("model_digit", 32'(digit), 32'(e_dig));
      check("model_frame", 32'(frame), 32'(e_frame));
      check("model_ack", 32'(lif.load_ack), 32'(e_ack));
      check("model_pending", 32'(lif.pending), 32'(e_pend));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    lif.load = 1'b1; lif.data = d; lif.dp = p; lif.blank = b;
    tick();
    lif.load = 1'b0;
  endtask

  // Advance to the next sample where FRAME is high; report LOAD_ACK there.
  task automatic goto_frame(input string name, output logic ack_seen);
    bit found = 0;
    ack_seen = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      tick();
      if (frame === 1'b1) begin
        found = 1;
        ack_seen = lif.load_ack;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: no FRAME within 80 cycles", name);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [7:0]  seg0;
    logic [3:0]  dig0;
  } vec_t;

  vec_t vecs[9];

  logic [3:0] slot_dig[4];
  logic [7:0] slot_seg[4];

  initial begin
    logic ack_seen;
    int   cnt;

    vecs[0] = '{16'h0000, 4'h0, 4'h0, 8'hC0, 4'hE};
    vecs[1] = '{16'h1115, 4'h1, 4'h0, 8'h12, 4'hE};
    vecs[2] = '{16'h0006, 4'h0, 4'h0, 8'h82, 4'hE};
    vecs[3] = '{16'h2228, 4'h0, 4'h1, 8'hFF, 4'hF};
    vecs[4] = '{16'h0009, 4'hE, 4'h0, 8'h90, 4'hE};
    vecs[5] = '{16'h000B, 4'h1, 4'h0, 8'h03, 4'hE};
    vecs[6] = '{16'h000C, 4'h0, 4'hE, 8'hC6, 4'hE};
    vecs[7] = '{16'hEEEE, 4'h0, 4'h0, 8'h86, 4'hE};
    vecs[8] = '{16'h7777, 4'hF, 4'h0, 8'h78, 4'hE};
    slot_dig = '{4'hE, 4'hD, 4'hB, 4'h7};
    slot_seg = '{8'h99, 8'hB0, 8'hA4, 8'hF9};

    rst_n = 1'b0; en = 1'b0;
    lif.load = 1'b0; lif.data = '0; lif.dp = '0; lif.blank = '0;
    ticks(3);
    check("reset_seg", 32'(seg), 32'hFF);
    check("reset_digit", 32'(digit), 32'hF);
    check("reset_pending", 32'(lif.pending), 32'h0);

    // Scan order after committing 1234
    rst_n = 1'b1; en = 1'b1;
    do_load(16'h1234, 4'h0, 4'h0);
    check("s1_first_frame_no_ack", 32'(lif.load_ack), 32'h0);
    goto_frame("s1_frame", ack_seen);
    check("s1_commit_ack", 32'(ack_seen), 32'h1);
    for (int p = 1; p < 32; p++) begin
      tick();
      check("s1_digit", 32'(digit), 32'((p % SD < BC) ? 4'hF : slot_dig[p / SD]));
      check("s1_seg", 32'(seg), 32'((p % SD < BC) ? 8'hFF : slot_seg[p / SD]));
    end

    // Double buffer: load in slot 2, display holds until next frame
    goto_frame("s2_frame_a", ack_seen);
    check("s2_no_ack", 32'(ack_seen), 32'h0);
    ticks(17);
    do_load(16'hABCD, 4'h0, 4'h0);
    check("s2_pending", 32'(lif.pending), 32'h1);
    check("s2_old_seg", 32'(seg), 32'hA4);
    goto_frame("s2_frame_b", ack_seen);
    check("s2_ack", 32'(ack_seen), 32'h1);
    check("s2_pending_clr", 32'(lif.pending), 32'h0);
    ticks(2);
    check("s2_new_seg", 32'(seg), 32'hA1);

    // Repeated load, then load exactly on the commit cycle
    ticks(8);
    do_load(16'h0001, 4'h0, 4'h0);
    do_load(16'h0002, 4'h0, 4'h0);
    ticks(19);
    do_load(16'h0003, 4'h0, 4'h0);
    check("s3_frame", 32'(frame), 32'h1);
    check("s3_ack", 32'(lif.load_ack), 32'h1);
    check("s3_pending_kept", 32'(lif.pending), 32'h1);
    ticks(2);
    check("s3_seg_0002", 32'(seg), 32'hA4);
    goto_frame("s3_frame_b", ack_seen);
    check("s3_ack_b", 32'(ack_seen), 32'h1);
    ticks(2);
    check("s3_seg_0003", 32'(seg), 32'hB0);

    // Blank digit 2, dp on digit 0
    do_load(16'h1234, 4'b0001, 4'b0100);
    goto_frame("s4_frame", ack_seen);
    check("s4_ack", 32'(ack_seen), 32'h1);
    cnt = 0;
    for (int p = 1; p < 32; p++) begin
      tick();
      if (p == 2) check("s4_dp_seg", 32'(seg), 32'h19);
      if (p >= 16 && p < 24 && digit !== 4'hF) cnt++;
    end
    check("s4_blank_slot", 32'(cnt), 32'h0);
    tick();
    check("s4_frame_len", 32'(frame), 32'h1);

    // Enable drop during slot 3, then resume
    ticks(26);
    check("s5_pre", 32'(digit), 32'h7);
    en = 1'b0;
    tick();
    check("s5_dark", 32'(digit), 32'hF);
    check("s5_no_frame", 32'(frame), 32'h0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (frame) cnt++;
    end
    check("s5_frames_off", 32'(cnt), 32'h0);
    en = 1'b1;
    tick();
    check("s5_resume_frame", 32'(frame), 32'h1);
    ticks(2);
    check("s5_resume_digit", 32'(digit), 32'hE);

    // Reset with a value pending
    do_load(16'h5555, 4'h0, 4'h0);
    ticks(2);
    rst_n = 1'b0;
    tick();
    check("s6_seg", 32'(seg), 32'hFF);
    check("s6_digit", 32'(digit), 32'hF);
    check("s6_pending", 32'(lif.pending), 32'h0);
    check("s6_ack", 32'(lif.load_ack), 32'h0);
    check("s6_frame", 32'(frame), 32'h0);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (lif.load_ack) cnt++;
    end
    check("s6_no_ack", 32'(cnt), 32'h0);
    goto_frame("s6_frame_b", ack_seen);
    ticks(2);
    check("s6_disp_zero", 32'(seg), 32'hC0);
    check("s6_disp_digit", 32'(digit), 32'hE);

    // Decode / dp / blank vector table, read at digit 0 drive
    foreach (vecs[i]) begin
      do_load(vecs[i].data, vecs[i].dp, vecs[i].blank);
      goto_frame("vec_frame", ack_seen);
      check("vec_ack", 32'(ack_seen), 32'h1);
      ticks(2);
      check("vec_seg", 32'(seg), 32'(vecs[i].seg0));
      check("vec_digit", 32'(digit), 32'(vecs[i].dig0));
    end

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      en       = ($urandom_range(0, 15) != 0);
      rst_n    = ($urandom_range(0, 299) != 0);
      lif.load = ($urandom_range(0, 11) == 0);
      lif.data = 16'($urandom);
      lif.dp   = 4'($urandom);
      lif.blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      tick();
    end
    lif.load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
